// File: rtl/debug_display_ctrl.sv
// rtl/debug_display_ctrl.sv - hex debug display with divided/stepped cpu clock; step FSM under `DEBUG_DISPLAY_STEP_EN
module debug_display_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = 2,
  parameter int DIV_BITS   = 24,
  parameter int DEB_BITS   = 16
) (
  input  logic                    clk50M,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic                    btn_page,
  input  logic                    btn_step,
  input  logic                    step_mode,
  output logic                    cpu_clk,
  output logic [7*NUM_DIGITS-1:0] segdisp,
  output logic [7:0]              page
);

  localparam int NIB = DATA_WIDTH / 4;
  localparam int NP  = (NIB + NUM_DIGITS - 1) / NUM_DIGITS;
  localparam logic [7:0] PAGE_LAST = 8'(NP - 1);

  // index 0 = btn_page, index 1 = btn_step
  logic [1:0]          btn_raw;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          deb_level;
  logic [1:0]          deb_level_q;
  logic [1:0]          press;
  logic [DEB_BITS-1:0] deb_cnt [2];

  logic [DIV_BITS-1:0]     div_cnt;
  logic                    div_hold;
  logic                    cpu_clk_q;
  logic                    tick;
  logic [DATA_WIDTH-1:0]   hold;
  logic [7*NUM_DIGITS-1:0] seg_next;

  assign btn_raw = {btn_step, btn_page};
  assign press   = deb_level & ~deb_level_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Segments for one digit; nibble slots past the end of the word stay dark.
  function automatic logic [6:0] digit_seg(input logic [DATA_WIDTH-1:0] h,
                                           input logic [7:0] pg, input int k);
    int idx;
    logic [DATA_WIDTH-1:0] sh;
    idx = int'(pg) * NUM_DIGITS + k;
    if (idx >= NIB) return 7'h00;
    sh = h >> (4 * idx);
    return hex7(sh[3:0]);
  endfunction

  // Two-flop synchroniser plus per-button stability counter; any bounce restarts the count.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      sync1       <= '0;
      sync2       <= '0;
      deb_level   <= '0;
      deb_level_q <= '0;
      deb_cnt[0]  <= '0;
      deb_cnt[1]  <= '0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      deb_level_q <= deb_level;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == deb_level[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == '1) begin
          deb_level[b] <= sync2[b];
          deb_cnt[b]   <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Free-running divider; parked at 0 while stepping so free-run restarts from a clean phase.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst)          div_cnt <= '0;
    else if (div_hold) div_cnt <= '0;
    else               div_cnt <= div_cnt + 1'b1;
  end

`ifdef DEBUG_DISPLAY_STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} step_state_t;

  step_state_t         state;
  step_state_t         state_next;
  logic [DIV_BITS-2:0] step_cnt;
  logic                step_done;

  assign step_done = (step_cnt == '1);
  assign div_hold  = step_mode || (state != S_IDLE);

  // Step FSM state register.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Half-period timer for HIGH and LOW; idles at 0 so each phase starts fresh.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst)                                step_cnt <= '0;
    else if (state == S_IDLE || step_done)   step_cnt <= '0;
    else                                     step_cnt <= step_cnt + 1'b1;
  end

  // Next state and cpu_clk source: a started step always runs to completion.
  always_comb begin
    state_next = state;
    cpu_clk    = div_cnt[DIV_BITS-1];
    case (state)
      S_IDLE: begin
        if (step_mode) cpu_clk = 1'b0;
        if (step_mode && press[1]) state_next = S_HIGH;
      end
      S_HIGH: begin
        cpu_clk = 1'b1;
        if (step_done) state_next = S_LOW;
      end
      S_LOW: begin
        cpu_clk = 1'b0;
        if (step_done) state_next = S_IDLE;
      end
      default: begin
        cpu_clk    = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end
`else
  logic unused_step;

  assign cpu_clk     = div_cnt[DIV_BITS-1];
  assign div_hold    = 1'b0;
  assign unused_step = &{1'b0, press[1], step_mode};
`endif

  assign tick = cpu_clk & ~cpu_clk_q;

  // Previous cpu_clk level, for rising-edge (tick) detection.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) cpu_clk_q <= 1'b0;
    else      cpu_clk_q <= cpu_clk;
  end

  // Snapshot of the monitored word, refreshed once per cpu clock rising edge.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst)      hold <= '0;
    else if (tick) hold <= data;
  end

  // Page index advances on each debounced page press and wraps after the last page.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst)          page <= 8'd0;
    else if (press[0]) page <= (page == PAGE_LAST) ? 8'd0 : page + 8'd1;
  end

  // Decode the visible nibbles of the current page.
  always_comb begin
    seg_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_next[7*k +: 7] = digit_seg(hold, page, k);
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) segdisp <= '0;
    else      segdisp <= seg_next;
  end

endmodule
